uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of received data word.
REQ-002 Parameter FIFO_DEPTH, default 4, receive buffer entries; SHALL be a power of two, at least 2.
REQ-003 CLK  in  1  sole clock; all logic SHALL be rising-edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 RX_IN  in  1  raw serial line, monitored only.
REQ-006 cfg_wr  in  1  one-cycle config write strobe.
REQ-007 cfg_par_en / cfg_par_type / cfg_prescale  in  1/1/6  requested config.
REQ-008 parity_enable / parity_type / Prescale  out  1/1/6  committed config driven to receiver.
REQ-009 cfg_pending  out  1  shadow config awaiting commit; cfg_err out 1 one-cycle pulse on rejected write.
REQ-010 rx_p_data  in  DATA_WIDTH; rx_data_valid / rx_parity_error / rx_framing_error  in  1 each; receiver outputs.
REQ-011 rd_en  in  1  pop strobe; rd_data  out  DATA_WIDTH+2  head entry {par_err, frm_err, data}.
REQ-012 fifo_empty / fifo_full / busy / overrun  out  1 each; ovr_clr  in  1  clears overrun.

Function
REQ-013 RX_IN SHALL pass a 2-flop synchronizer; falling edge detected on synchronized value, one extra register.
REQ-014 FSM states SHALL be IDLE, FRAME, COMMIT; busy=1 in FRAME only.
REQ-015 IDLE->COMMIT when cfg_pending=1 (priority); else IDLE->FRAME on detected falling edge.
REQ-016 COMMIT SHALL last one cycle: copy shadow to outputs, clear cfg_pending, then go FRAME if a falling edge was detected that cycle, else IDLE.
REQ-017 FRAME->IDLE on rx_data_valid, on rising edge of rx_parity_error or rx_framing_error, or when the 10-bit frame timer reaches Prescale*12-1.
REQ-018 Frame timer SHALL clear on entry to FRAME and increment each cycle in FRAME; product computed at 10 bits, no truncation (max 756).
REQ-019 cfg_wr with cfg_prescale in {8,16,32} SHALL load shadow and set cfg_pending next cycle; a new write while pending overwrites shadow.
REQ-020 cfg_wr with any other prescale SHALL be ignored and pulse cfg_err the next cycle; shadow unchanged.
REQ-021 Committed config SHALL never change while in FRAME.
REQ-022 Push SHALL occur on rx_data_valid or on error rising edge in FRAME; entry = {rx_parity_error, rx_framing_error, rx_p_data} sampled that cycle; at most one push per frame.
REQ-023 rd_data SHALL show the head entry combinationally (first-word fall-through); holds last value when empty.
REQ-024 rd_en when empty SHALL be ignored.
REQ-025 Simultaneous push and pop when full SHALL succeed (occupancy unchanged, no overrun).
REQ-026 Push when full without pop SHALL drop the entry and set overrun; overrun sticky until ovr_clr; set wins over simultaneous clear.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-028 On RST low: state IDLE, Prescale=8, parity_enable=0, parity_type=0, cfg_pending=0, cfg_err=0, FIFO empty, rd_data=0, overrun=0, busy=0, synchronizer flops=1.
REQ-029 Reset mid-frame or mid-commit SHALL discard shadow config and FIFO contents immediately.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state enum (IDLE, FRAME, COMMIT), the legal prescale constants, and the frame-bit count 12.
REQ-031 FIFO SHALL be a sub-module uart_rx_fifo; FSM, synchronizer and config logic stay in uart_rx_ctrl.

Verification
REQ-032 Reset, then cfg_wr prescale=16, par_en=1 while idle -> cfg_pending 1 cycle later, COMMIT next, Prescale=16, parity_enable=1.
REQ-033 cfg_wr prescale=16 during FRAME -> outputs stay 8 until rx_data_valid, commit occurs the cycle after IDLE re-entry.
REQ-034 cfg_wr prescale=12 -> cfg_err pulse, Prescale unchanged, cfg_pending 0.
REQ-035 Five frames 0xA5,0x3C,0x00,0xFF,0x81, no reads, depth 4 -> fifo_full, overrun=1, reads return first four in order, flags 00.
REQ-036 Falling edge with no receiver response, Prescale=8 -> busy drops after 96 cycles, no push.
REQ-037 Frame with rx_parity_error rising, data 0x55 -> entry {1,0,0x55}; simultaneous push/pop at full -> overrun stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encodings, legal prescale values and frame length for the UART receive controller.
package uart_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [5:0] PRESCALE_8 = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;
  localparam int FRAME_BITS = 12;
  function automatic logic is_legal_prescale(input logic [5:0] p);
    return p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through receive buffer with sticky overrun flag.
module uart_rx_fifo #(
  parameter int W = 10,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic         ovr_clr,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full,
  output logic         overrun
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [W-1:0] last_q, last_d;
  logic ovr_q, ovr_d, do_push, do_pop;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (AW+1)'(DEPTH);
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    // last popped word stays visible once the buffer runs dry
    last_d = do_pop ? mem[rd_q] : last_q;
    ovr_d = (push & ~do_push) ? 1'b1 : ovr_clr ? 1'b0 : ovr_q;
    rd_data = empty ? last_q : mem[rd_q];
    overrun = ovr_q;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      last_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      ovr_q <= ovr_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_q] <= wr_data;
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame supervisor for a UART receiver -- line edge detect, safe config commit, status buffering.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  cfg_wr,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_type,
  input  logic [5:0]            cfg_prescale,
  output logic                  parity_enable,
  output logic                  parity_type,
  output logic [5:0]            Prescale,
  output logic                  cfg_pending,
  output logic                  cfg_err,
  input  logic [DATA_WIDTH-1:0] rx_p_data,
  input  logic                  rx_data_valid,
  input  logic                  rx_parity_error,
  input  logic                  rx_framing_error,
  input  logic                  rd_en,
  output logic [DATA_WIDTH+1:0] rd_data,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  ovr_clr
);
  logic s1_q, s2_q, s3_q, par_q, frm_q;
  logic [1:0] state_q, state_d;
  logic [9:0] timer_q, timer_d, limit;
  logic sh_pe_q, sh_pe_d, sh_pt_q, sh_pt_d, pe_q, pe_d, pt_q, pt_d;
  logic [5:0] sh_ps_q, sh_ps_d, ps_q, ps_d;
  logic pend_q, pend_d, err_q, err_d;
  logic fall, err_rise, in_frame, commit, push, wr_ok;
  always_comb begin
    fall = s3_q & ~s2_q;
    err_rise = (rx_parity_error & ~par_q) | (rx_framing_error & ~frm_q);
    limit = 10'(ps_q) * 10'(FRAME_BITS) - 10'd1;
    in_frame = state_q == ST_FRAME;
    commit = state_q == ST_COMMIT;
    push = in_frame & (rx_data_valid | err_rise);
    wr_ok = cfg_wr & is_legal_prescale(cfg_prescale);
    // a pending commit outranks a new frame start while idle
    state_d = state_q == ST_IDLE ? (pend_q ? ST_COMMIT : fall ? ST_FRAME : ST_IDLE) :
              commit ? (fall ? ST_FRAME : ST_IDLE) :
              in_frame ? ((push | timer_q == limit) ? ST_IDLE : ST_FRAME) : ST_IDLE;
    timer_d = in_frame ? timer_q + 10'd1 : 10'd0;
    sh_pe_d = wr_ok ? cfg_par_en : sh_pe_q;
    sh_pt_d = wr_ok ? cfg_par_type : sh_pt_q;
    sh_ps_d = wr_ok ? cfg_prescale : sh_ps_q;
    pend_d = wr_ok | (pend_q & ~commit);
    err_d = cfg_wr & ~wr_ok;
    pe_d = commit ? sh_pe_q : pe_q;
    pt_d = commit ? sh_pt_q : pt_q;
    ps_d = commit ? sh_ps_q : ps_q;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
      par_q <= 1'b0;
      frm_q <= 1'b0;
      state_q <= ST_IDLE;
      timer_q <= '0;
      sh_pe_q <= 1'b0;
      sh_pt_q <= 1'b0;
      sh_ps_q <= PRESCALE_8;
      pend_q <= 1'b0;
      err_q <= 1'b0;
      pe_q <= 1'b0;
      pt_q <= 1'b0;
      ps_q <= PRESCALE_8;
    end else begin
      s1_q <= RX_IN;
      s2_q <= s1_q;
      s3_q <= s2_q;
      par_q <= rx_parity_error;
      frm_q <= rx_framing_error;
      state_q <= state_d;
      timer_q <= timer_d;
      sh_pe_q <= sh_pe_d;
      sh_pt_q <= sh_pt_d;
      sh_ps_q <= sh_ps_d;
      pend_q <= pend_d;
      err_q <= err_d;
      pe_q <= pe_d;
      pt_q <= pt_d;
      ps_q <= ps_d;
    end
  end
  assign parity_enable = pe_q;
  assign parity_type = pt_q;
  assign Prescale = ps_q;
  assign cfg_pending = pend_q;
  assign cfg_err = err_q;
  assign busy = in_frame;
  uart_rx_fifo #(.W(DATA_WIDTH + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK),
    .RST(RST),
    .push(push),
    .pop(rd_en),
    .ovr_clr(ovr_clr),
    .wr_data({rx_parity_error, rx_framing_error, rx_p_data}),
    .rd_data(rd_data),
    .empty(fifo_empty),
    .full(fifo_full),
    .overrun(overrun)
  );
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed checks of config commit, frame supervision and receive buffering.
module tb_uart_rx_ctrl;
  logic CLK, RST, RX_IN, cfg_wr, cfg_par_en, cfg_par_type;
  logic [5:0] cfg_prescale, Prescale;
  logic parity_enable, parity_type, cfg_pending, cfg_err;
  logic [7:0] rx_p_data;
  logic rx_data_valid, rx_parity_error, rx_framing_error, rd_en, ovr_clr;
  logic [9:0] rd_data;
  logic fifo_empty, fifo_full, busy, overrun;
  int total, bad;
  uart_rx_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .cfg_wr(cfg_wr), .cfg_par_en(cfg_par_en),
    .cfg_par_type(cfg_par_type), .cfg_prescale(cfg_prescale), .parity_enable(parity_enable),
    .parity_type(parity_type), .Prescale(Prescale), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .rx_p_data(rx_p_data), .rx_data_valid(rx_data_valid), .rx_parity_error(rx_parity_error),
    .rx_framing_error(rx_framing_error), .rd_en(rd_en), .rd_data(rd_data), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
  );
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic frame_start(input string tag);
    RX_IN = 0;
    repeat (3) tick();
    chk({tag, "_busy"}, busy, 1);
    RX_IN = 1;
  endtask
  task automatic frame_end(input logic [7:0] d, input logic pe, input logic fe, input logic pop);
    rx_p_data = d;
    rx_data_valid = ~pe & ~fe;
    rx_parity_error = pe;
    rx_framing_error = fe;
    rd_en = pop;
    tick();
    rx_data_valid = 0;
    rx_parity_error = 0;
    rx_framing_error = 0;
    rd_en = 0;
  endtask
  task automatic frame(input string tag, input logic [7:0] d, input logic pe, input logic fe, input logic pop);
    frame_start(tag);
    frame_end(d, pe, fe, pop);
    chk({tag, "_idle"}, busy, 0);
    repeat (2) tick();
  endtask
  task automatic pop_chk(input string tag, input logic [9:0] exp);
    chk(tag, rd_data, exp);
    rd_en = 1;
    tick();
    rd_en = 0;
  endtask
  initial begin
    total = 0;
    bad = 0;
    RST = 0; RX_IN = 1; cfg_wr = 0; cfg_par_en = 0; cfg_par_type = 0; cfg_prescale = 0;
    rx_p_data = 0; rx_data_valid = 0; rx_parity_error = 0; rx_framing_error = 0; rd_en = 0; ovr_clr = 0;
    tick();
    chk("rst_ps", Prescale, 8);
    chk("rst_pe", parity_enable, 0);
    chk("rst_pt", parity_type, 0);
    chk("rst_pend", cfg_pending, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    RST = 1;
    tick();
    // silent line: 8*12 = 96 cycles in FRAME, then back to idle with nothing buffered
    frame_start("to");
    repeat (95) tick();
    chk("to_95", busy, 1);
    tick();
    chk("to_96", busy, 0);
    chk("to_empty", fifo_empty, 1);
    tick();
    frame_start("mid");
    cfg_wr = 1; cfg_prescale = 16; cfg_par_en = 0; cfg_par_type = 0;
    tick();
    cfg_wr = 0;
    chk("mid_pend", cfg_pending, 1);
    chk("mid_ps", Prescale, 8);
    chk("mid_busy", busy, 1);
    tick();
    frame_end(8'hA5, 0, 0, 0);
    chk("mid_idle", busy, 0);
    chk("mid_ps_idle", Prescale, 8);
    tick();
    chk("mid_ps_commit", Prescale, 8);
    tick();
    chk("mid_ps_done", Prescale, 16);
    chk("mid_pend_done", cfg_pending, 0);
    chk("mid_head", rd_data, 10'h0A5);
    pop_chk("mid_pop", 10'h0A5);
    chk("mid_empty", fifo_empty, 1);
    chk("mid_hold", rd_data, 10'h0A5);
    cfg_wr = 1; cfg_prescale = 16; cfg_par_en = 1; cfg_par_type = 1;
    tick();
    cfg_wr = 0;
    chk("c16_pend", cfg_pending, 1);
    chk("c16_pe_pre", parity_enable, 0);
    tick();
    chk("c16_pe_commit", parity_enable, 0);
    tick();
    chk("c16_pe", parity_enable, 1);
    chk("c16_pt", parity_type, 1);
    chk("c16_ps", Prescale, 16);
    chk("c16_pend_clr", cfg_pending, 0);
    cfg_wr = 1; cfg_prescale = 12; cfg_par_en = 0; cfg_par_type = 0;
    tick();
    cfg_wr = 0;
    chk("c12_err", cfg_err, 1);
    chk("c12_pend", cfg_pending, 0);
    tick();
    chk("c12_err_off", cfg_err, 0);
    chk("c12_ps", Prescale, 16);
    chk("c12_pe", parity_enable, 1);
    frame("f0", 8'hA5, 0, 0, 0);
    frame("f1", 8'h3C, 0, 0, 0);
    frame("f2", 8'h00, 0, 0, 0);
    chk("f2_full", fifo_full, 0);
    frame("f3", 8'hFF, 0, 0, 0);
    chk("f3_full", fifo_full, 1);
    chk("f3_ovr", overrun, 0);
    frame("f4", 8'h81, 0, 0, 0);
    chk("f4_full", fifo_full, 1);
    chk("f4_ovr", overrun, 1);
    pop_chk("rd0", 10'h0A5);
    pop_chk("rd1", 10'h03C);
    pop_chk("rd2", 10'h000);
    pop_chk("rd3", 10'h0FF);
    chk("rd_empty", fifo_empty, 1);
    chk("rd_hold", rd_data, 10'h0FF);
    pop_chk("rd_extra", 10'h0FF);
    chk("rd_extra_empty", fifo_empty, 1);
    chk("ovr_sticky", overrun, 1);
    ovr_clr = 1;
    tick();
    ovr_clr = 0;
    chk("ovr_clr", overrun, 0);
    frame("pe", 8'h55, 1, 0, 0);
    chk("pe_entry", rd_data, 10'h255);
    frame("g1", 8'h11, 0, 0, 0);
    frame("g2", 8'h22, 0, 0, 0);
    frame("g3", 8'h33, 0, 0, 0);
    chk("g_full", fifo_full, 1);
    frame("pp", 8'h44, 0, 0, 1);
    chk("pp_full", fifo_full, 1);
    chk("pp_ovr", overrun, 0);
    pop_chk("pp0", 10'h011);
    pop_chk("pp1", 10'h022);
    pop_chk("pp2", 10'h033);
    pop_chk("pp3", 10'h044);
    chk("pp_empty", fifo_empty, 1);
    frame("fe", 8'h5A, 0, 1, 0);
    chk("fe_entry", rd_data, 10'h15A);
    cfg_wr = 1; cfg_prescale = 32; cfg_par_en = 0; cfg_par_type = 0;
    tick();
    cfg_wr = 0;
    chk("ar_pend", cfg_pending, 1);
    RST = 0;
    #1;
    chk("ar_empty", fifo_empty, 1);
    chk("ar_pend_clr", cfg_pending, 0);
    chk("ar_rd", rd_data, 0);
    chk("ar_ps", Prescale, 8);
    tick();
    RST = 1;
    repeat (3) tick();
    chk("ar_ps_after", Prescale, 8);
    chk("ar_pe_after", parity_enable, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
